// File: rtl/softmax_mac_seq_pkg.sv
// Shared definitions for the sequential softmax MAC block.
//   - CPU address regions (ADR[17:16]) and control register offsets
//   - CTRL / STATUS bit positions
//   - controller state encoding
//   - sat_add: signed add clamped to a w-bit two's complement range
package softmax_mac_seq_pkg;

  localparam logic [1:0] REGION_W   = 2'b00;
  localparam logic [1:0] REGION_X   = 2'b01;
  localparam logic [1:0] REGION_B   = 2'b10;
  localparam logic [1:0] REGION_CTL = 2'b11;

  localparam logic [15:0] OFS_CTRL    = 16'h0000;
  localparam logic [15:0] OFS_STATUS  = 16'h0001;
  localparam logic [15:0] OFS_ARGMAX  = 16'h0002;
  localparam logic [7:0]  RESULT_PAGE = 8'h01;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_DONE_BIT = 1;
  localparam int ST_ERR_BIT  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_STORE
  } state_t;

  // Operands must already lie inside the w-bit range (w <= 63), so the
  // 64-bit sum cannot overflow; only the clamp to w bits is needed.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM, read-before-write, one-cycle registered read.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : data at addr from the previous cycle (old data on a write)
module sp_ram_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/softmax_mac_seq.sv
// Time-multiplexed softmax front end: N_CLASS dot products of N_PIX pixels
// computed on one MAC pipeline, with CPU-visible weight/image/bias RAMs,
// per-class results, argmax and a done interrupt.
//   CLK      : clock          RESET_X : async active-low reset
//   WR / RD  : CPU strobes    ADR     : word address (region in [17:16])
//   WDATA    : write data     RDATA   : read data, valid the cycle after RD
//   DONE_IRQ : one-cycle pulse at the end of a run
//
// state   | meaning
// IDLE    | CPU owns the RAM ports, waiting for start
// BIAS    | bias read for class c issued
// MAC     | weight/image read p issued, p = 0..N_PIX-1
// DRAIN   | two cycles for the last product to reach the accumulator
// STORE   | accumulator written to RESULT_c, argmax updated
module softmax_mac_seq
  import softmax_mac_seq_pkg::*;
#(
  parameter int N_PIX   = 784,
  parameter int N_CLASS = 46,
  parameter int DW      = 8,
  parameter int ACC_W   = 32
) (
  input  logic        CLK,
  input  logic        RESET_X,
  input  logic        WR,
  input  logic        RD,
  input  logic [17:0] ADR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        DONE_IRQ
);

  localparam int W_DEPTH = N_CLASS * N_PIX;
  localparam int WAW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int XAW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int BAW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int PW  = 2 * DW + 1;
  localparam logic [XAW-1:0] PIX_LAST = XAW'(N_PIX - 1);
  localparam logic [BAW-1:0] CLS_LAST = BAW'(N_CLASS - 1);

  state_t state_q, state_d;
  logic [BAW-1:0] cls_q, cls_d;
  logic [XAW-1:0] pix_q, pix_d;
  logic [WAW-1:0] w_ptr_q, w_ptr_d;
  logic drn_q, drn_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic rd_vld_q, rd_vld_d, bias_vld_q, bias_vld_d, prod_vld_q, prod_vld_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, best_q, best_d;
  logic signed [ACC_W-1:0] results_q [N_CLASS];
  logic signed [ACC_W-1:0] results_d [N_CLASS];
  logic [7:0]  argmax_q, argmax_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_pend_q, ram_pend_d;
  logic [1:0]  ram_sel_q, ram_sel_d;

  logic [1:0]  region;
  logic [15:0] ofs;
  logic [31:0] ofs32;
  logic busy, in_range, mem_wr, ctl_wr, ram_rd;
  logic [DW-1:0] w_dout, x_dout, b_dout;
  logic [WAW-1:0] w_addr;
  logic [XAW-1:0] x_addr;
  logic [BAW-1:0] b_addr;
  logic [31:0] reg_val, ram_val;
  logic signed [63:0] sum_sat;

  assign region = ADR[17:16];
  assign ofs    = ADR[15:0];
  assign ofs32  = {16'd0, ofs};
  assign busy   = (state_q != S_IDLE);
  assign mem_wr = WR && (region != REGION_CTL);
  assign ctl_wr = WR && (region == REGION_CTL) && (ofs == OFS_CTRL);
  assign ram_rd = RD && !busy && (region != REGION_CTL) && in_range;

  always_comb begin
    in_range = 1'b0;
    case (region)
      REGION_W: in_range = (ofs32 < W_DEPTH);
      REGION_X: in_range = (ofs32 < N_PIX);
      REGION_B: in_range = (ofs32 < N_CLASS);
      default:  in_range = 1'b0;
    endcase
  end

  // RAM ports belong to the CPU while idle and to the sequencer while busy.
  assign w_addr = busy ? w_ptr_q : ofs[WAW-1:0];
  assign x_addr = busy ? pix_q   : ofs[XAW-1:0];
  assign b_addr = busy ? cls_q   : ofs[BAW-1:0];

  sp_ram_sync #(.DEPTH(W_DEPTH), .WIDTH(DW)) u_w_ram (
    .clk(CLK), .we(mem_wr && !busy && in_range && region == REGION_W),
    .addr(w_addr), .wdata(WDATA[DW-1:0]), .rdata(w_dout));
  sp_ram_sync #(.DEPTH(N_PIX), .WIDTH(DW)) u_x_ram (
    .clk(CLK), .we(mem_wr && !busy && in_range && region == REGION_X),
    .addr(x_addr), .wdata(WDATA[DW-1:0]), .rdata(x_dout));
  sp_ram_sync #(.DEPTH(N_CLASS), .WIDTH(DW)) u_b_ram (
    .clk(CLK), .we(mem_wr && !busy && in_range && region == REGION_B),
    .addr(b_addr), .wdata(WDATA[DW-1:0]), .rdata(b_dout));

  always_comb begin
    reg_val = '0;
    if (region == REGION_CTL) begin
      if (ofs == OFS_STATUS) begin
        reg_val[ST_BUSY_BIT] = busy;
        reg_val[ST_DONE_BIT] = done_q;
        reg_val[ST_ERR_BIT]  = err_q;
      end else if (ofs == OFS_ARGMAX) begin
        reg_val = {24'd0, argmax_q};
      end else if (ofs[15:8] == RESULT_PAGE && {24'd0, ofs[7:0]} < N_CLASS) begin
        reg_val = 32'(results_q[ofs[BAW-1:0]]);
      end
    end
  end

  always_comb begin
    ram_val = '0;
    case (ram_sel_q)
      REGION_W: ram_val = 32'($signed(w_dout));
      REGION_X: ram_val = 32'(x_dout);
      REGION_B: ram_val = 32'($signed(b_dout));
      default:  ram_val = '0;
    endcase
  end

  // RAM read data arrives straight from the RAM output register; it is
  // captured into rdata_q so it holds after the sequencer reuses the port.
  assign RDATA    = ram_pend_q ? ram_val : rdata_q;
  assign DONE_IRQ = irq_q;

  assign sum_sat = sat_add(64'(acc_q), 64'(prod_q), ACC_W);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    pix_d      = pix_q;
    w_ptr_d    = w_ptr_q;
    drn_d      = drn_q;
    done_d     = done_q;
    err_d      = err_q;
    irq_d      = 1'b0;
    results_d  = results_q;
    argmax_d   = argmax_q;
    best_d     = best_q;
    rd_vld_d   = (state_q == S_MAC);
    bias_vld_d = (state_q == S_BIAS);
    prod_vld_d = rd_vld_q;
    prod_d     = PW'($signed(w_dout)) * PW'($signed({1'b0, x_dout}));
    acc_d      = acc_q;
    if (bias_vld_q)      acc_d = ACC_W'($signed(b_dout));
    else if (prod_vld_q) acc_d = sum_sat[ACC_W-1:0];

    case (state_q)
      S_IDLE: if (ctl_wr && WDATA[CTRL_START_BIT]) begin
        state_d = S_BIAS;
        cls_d   = '0;
        pix_d   = '0;
        w_ptr_d = '0;
        done_d  = 1'b0;
      end
      S_BIAS: state_d = S_MAC;
      S_MAC: begin
        w_ptr_d = w_ptr_q + WAW'(1);
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          drn_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          pix_d = pix_q + XAW'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q) state_d = S_STORE;
        else       drn_d   = 1'b1;
      end
      S_STORE: begin
        results_d[cls_q] = acc_q;
        if (cls_q == '0 || acc_q > best_q) begin
          argmax_d = 8'(cls_q);
          best_d   = acc_q;
        end
        if (cls_q == CLS_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end else begin
          cls_d   = cls_q + BAW'(1);
          state_d = S_BIAS;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear during a run only touches err; done belongs to the run.
    if (ctl_wr && WDATA[CTRL_CLEAR_BIT]) begin
      err_d = 1'b0;
      if (!busy) done_d = 1'b0;
    end
    if (mem_wr && busy) err_d = 1'b1;

    ram_pend_d = ram_rd;
    ram_sel_d  = ram_rd ? region : ram_sel_q;
    rdata_d    = rdata_q;
    if (ram_pend_q)     rdata_d = ram_val;
    if (RD && !ram_rd)  rdata_d = reg_val;
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q    <= S_IDLE;
      cls_q      <= '0;
      pix_q      <= '0;
      w_ptr_q    <= '0;
      drn_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      bias_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      argmax_q   <= '0;
      rdata_q    <= '0;
      ram_pend_q <= 1'b0;
      ram_sel_q  <= REGION_CTL;
      for (int i = 0; i < N_CLASS; i++) results_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      pix_q      <= pix_d;
      w_ptr_q    <= w_ptr_d;
      drn_q      <= drn_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      rd_vld_q   <= rd_vld_d;
      bias_vld_q <= bias_vld_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      argmax_q   <= argmax_d;
      rdata_q    <= rdata_d;
      ram_pend_q <= ram_pend_d;
      ram_sel_q  <= ram_sel_d;
      results_q  <= results_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{WDATA[31:DW], sum_sat[63:ACC_W]};

endmodule

// File: tb/tb_softmax_mac_seq.sv
module tb_softmax_mac_seq;

  localparam logic [17:0] A_CTRL   = 18'h30000;
  localparam logic [17:0] A_STATUS = 18'h30001;
  localparam logic [17:0] A_ARGMAX = 18'h30002;
  localparam logic [17:0] A_RES    = 18'h30100;
  localparam logic [17:0] A_X      = 18'h10000;
  localparam logic [17:0] A_B      = 18'h20000;

  logic clk, rst_x, wr, rd, sel;
  logic [17:0] adr;
  logic [31:0] wdata, rdata_a, rdata_b;
  logic irq_a, irq_b;
  logic rd_d1 = 1'b0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          b;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int irq_q_a[$];
  int irq_q_b[$];
  int irq_cnt_a = 0;
  int irq_cnt_b = 0;
  int total = 0;
  int bad = 0;

  softmax_mac_seq #(.N_PIX(4), .N_CLASS(3), .DW(8), .ACC_W(32)) dut_a (
    .CLK(clk), .RESET_X(rst_x), .WR(wr & ~sel), .RD(rd & ~sel), .ADR(adr),
    .WDATA(wdata), .RDATA(rdata_a), .DONE_IRQ(irq_a));

  softmax_mac_seq #(.N_PIX(784), .N_CLASS(2), .DW(8), .ACC_W(18)) dut_b (
    .CLK(clk), .RESET_X(rst_x), .WR(wr & sel), .RD(rd & sel), .ADR(adr),
    .WDATA(wdata), .RDATA(rdata_b), .DONE_IRQ(irq_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_d1 <= rd;
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: read responses and IRQ pulses against the queued expectations.
  always @(negedge clk) begin
    if (rd_d1) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: read data with no expectation at cycle %0d", cyc);
      end else begin
        e = sb_q.pop_front();
        check(e.name, e.b ? rdata_b : rdata_a, e.exp);
      end
    end
    if (irq_a === 1'b1) begin
      irq_cnt_a++;
      if (irq_q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL irq_a_unexpected: pulse at cycle %0d, none expected", cyc);
      end else check("irq_a_cycle", 32'(cyc), 32'(irq_q_a.pop_front()));
    end
    if (irq_b === 1'b1) begin
      irq_cnt_b++;
      if (irq_q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL irq_b_unexpected: pulse at cycle %0d, none expected", cyc);
      end else check("irq_b_cycle", 32'(cyc), 32'(irq_q_b.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [17:0] a, input logic [31:0] d);
    wr = 1'b1; adr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic push_exp(input string nm, input logic [31:0] ev);
    exp_t x;
    x.name = nm; x.exp = ev; x.b = sel;
    sb_q.push_back(x);
  endtask

  task automatic bus_rd(input logic [17:0] a, input string nm, input logic [31:0] ev);
    push_exp(nm, ev);
    rd = 1'b1; adr = a;
    step();
    rd = 1'b0;
  endtask

  task automatic bus_wrrd(input logic [17:0] a, input logic [31:0] d,
                          input string nm, input logic [31:0] ev);
    push_exp(nm, ev);
    wr = 1'b1; rd = 1'b1; adr = a; wdata = d;
    step();
    wr = 1'b0; rd = 1'b0;
  endtask

  // lat = 0 means the run is not expected to finish.
  task automatic start_run(input int lat, output int t);
    t = cyc;
    if (lat != 0) begin
      if (sel) irq_q_b.push_back(cyc + lat);
      else     irq_q_a.push_back(cyc + lat);
    end
    bus_wr(A_CTRL, 32'd1);
  endtask

  task automatic wait_run(input int budget);
    int c0;
    int k;
    c0 = sel ? irq_cnt_b : irq_cnt_a;
    k = 0;
    while ((sel ? irq_cnt_b : irq_cnt_a) == c0 && k < budget) begin
      step();
      k++;
    end
    total++;
    if ((sel ? irq_cnt_b : irq_cnt_a) == c0) begin
      bad++;
      $display("FAIL irq_timeout: no DONE_IRQ within %0d cycles", budget);
    end
  endtask

  int img[4]  = '{1, 2, 3, 4};
  int wg[12]  = '{1, 1, 1, 1, -1, 0, 0, 0, 2, 2, 2, 2};
  int bg[3]   = '{5, 0, -3};
  int rg[3]   = '{15, -1, 17};
  int rt[3]   = '{10, 3, 10};

  task automatic check_golden(input string tag);
    for (int c = 0; c < 3; c++) bus_rd(A_RES + 18'(c), {tag, "_result"}, 32'(rg[c]));
    bus_rd(A_ARGMAX, {tag, "_argmax"}, 32'd2);
  endtask

  initial begin
    int t;
    rst_x = 1'b0; wr = 1'b0; rd = 1'b0; sel = 1'b0; adr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_x = 1'b1;

    check("rdata_reset", rdata_a, 32'd0);
    bus_rd(A_STATUS, "status_reset", 32'd0);
    bus_rd(A_ARGMAX, "argmax_reset", 32'd0);
    for (int c = 0; c < 3; c++) bus_rd(A_RES + 18'(c), "result_reset", 32'd0);

    // Simultaneous write and read: read sees the old contents.
    bus_wr(A_X + 18'd3, 32'd9);
    bus_wrrd(A_X + 18'd3, 32'd4, "wr_rd_same", 32'd9);
    bus_rd(A_X + 18'd3, "img_after_wr", 32'd4);

    for (int p = 0; p < 4; p++) bus_wr(A_X + 18'(p), 32'(img[p]));
    for (int i = 0; i < 12; i++) bus_wr(18'(i), 32'(wg[i]));
    for (int c = 0; c < 3; c++) bus_wr(A_B + 18'(c), 32'(bg[c]));
    bus_rd(18'h00004, "weight_readback", 32'hFFFF_FFFF);
    bus_rd(A_B + 18'd2, "bias_readback", 32'hFFFF_FFFD);
    bus_rd(A_X + 18'd1, "img_readback", 32'd2);

    // Golden run.
    start_run(25, t);
    wait_run(200);
    check_golden("gold");
    bus_rd(A_STATUS, "status_done", 32'd2);

    // Start and image write while busy.
    start_run(25, t);
    step(); step();
    bus_wr(A_CTRL, 32'd1);
    bus_wr(A_X, 32'd77);
    bus_rd(A_STATUS, "status_busy_err", 32'd5);
    wait_run(200);
    bus_rd(A_STATUS, "status_after_err", 32'd6);
    bus_rd(A_X, "img_write_dropped", 32'd1);
    check_golden("rerun");
    bus_wr(A_CTRL, 32'd2);
    bus_rd(A_STATUS, "status_cleared", 32'd0);

    // Tie between class 0 and class 2.
    bus_wr(18'd4, 32'd3);
    bus_wr(A_B + 18'd0, 32'd0);
    bus_wr(A_B + 18'd2, 32'hFFFF_FFF6);
    start_run(25, t);
    wait_run(200);
    for (int c = 0; c < 3; c++) bus_rd(A_RES + 18'(c), "tie_result", 32'(rt[c]));
    bus_rd(A_ARGMAX, "tie_argmax", 32'd0);

    // Reset during class 1 MAC.
    start_run(0, t);
    bus_rd(A_RES, "result_hold_busy", 32'd10);
    while (cyc < t + 11) step();
    rst_x = 1'b0;
    @(negedge clk);
    check("rdata_mid_reset", rdata_a, 32'd0);
    step();
    rst_x = 1'b1;
    bus_rd(A_STATUS, "status_after_rst", 32'd0);
    bus_rd(A_ARGMAX, "argmax_after_rst", 32'd0);
    for (int c = 0; c < 3; c++) bus_rd(A_RES + 18'(c), "result_after_rst", 32'd0);
    repeat (40) step();
    bus_wr(18'd4, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) bus_wr(A_B + 18'(c), 32'(bg[c]));
    start_run(25, t);
    wait_run(200);
    check_golden("post_rst");

    // Out-of-range read and RDATA hold.
    bus_rd(A_RES + 18'd2, "result2_for_hold", 32'd17);
    repeat (3) step();
    check("rdata_hold", rdata_a, 32'd17);
    bus_rd(A_RES + 18'd3, "result_out_of_range", 32'd0);

    // Saturation instance: ACC_W=18, N_PIX=784, two classes.
    sel = 1'b1;
    for (int i = 0; i < 784; i++) bus_wr(18'(i), 32'h7F);
    for (int i = 784; i < 1568; i++) bus_wr(18'(i), 32'h80);
    for (int p = 0; p < 784; p++) bus_wr(A_X + 18'(p), 32'hFF);
    bus_wr(A_B, 32'd0);
    bus_wr(A_B + 18'd1, 32'd0);
    start_run(1 + 2 * 788, t);
    wait_run(3000);
    bus_rd(A_RES, "sat_pos", 32'h0001_FFFF);
    bus_rd(A_RES + 18'd1, "sat_neg", 32'hFFFE_0000);
    bus_rd(A_ARGMAX, "sat_argmax", 32'd0);
    sel = 1'b0;
    repeat (3) step();

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    check("irq_a_missing", 32'(irq_q_a.size()), 32'd0);
    check("irq_b_missing", 32'(irq_q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/softmax_mac_seq.md
# softmax_mac_seq

Parametrised, time-multiplexed successor to the 46-way parallel softmax classifier front end. It holds the weight, image and bias memories internally behind the same CPU register bus. A single multiply-accumulate pipeline computes `N_CLASS` dot products of `N_PIX` pixels sequentially, instead of 46 hard-wired parallel lanes. It adds start/busy/done control, saturating accumulation, argmax and a done interrupt; results stay CPU-readable.

## Interface
- `N_PIX`, 784: pixels per image (weights per class).
- `N_CLASS`, 46: number of output classes; ≤ 256.
- `DW`, 8: pixel/weight/bias data width.
- `ACC_W`, 32: accumulator and result width; ≥ 2·DW+2.
- `CLK` in 1: single clock; all logic on rising edge.
- `RESET_X` in 1: asynchronous, active-low reset.
- `WR` in 1: CPU write strobe, one cycle per access.
- `RD` in 1: CPU read strobe, one cycle per access.
- `ADR` in 18: CPU word address.
- `WDATA` in 32: CPU write data.
- `RDATA` out 32: CPU read data, registered.
- `DONE_IRQ` out 1: one-cycle pulse when a run completes.

## Operation
- Address map:
  - `ADR[17:16]=00`: weight RAM, offset `c·N_PIX+p`, `WDATA[DW-1:0]`, signed.
  - `01`: image RAM, offset `p`, unsigned.
  - `10`: bias RAM, offset `c`, signed.
  - `11`: control.
- Control registers:
  - `0x30000` CTRL: write bit0=1 starts a run; bit1=1 clears `done` and `err`.
  - `0x30001` STATUS, read-only: bit0 `busy`, bit1 `done`, bit2 `err`.
  - `0x30002` ARGMAX: index of the largest result.
  - `0x30100+c` RESULT_c, for `c < N_CLASS`.
- Out-of-range writes are dropped. Out-of-range reads return 0.
- FSM states: IDLE → BIAS (1 cycle, issue bias read for c) → MAC (`N_PIX` cycles, issue weight/image reads p=0..N_PIX-1) → DRAIN (2 cycles) → STORE (1 cycle).
  - From STORE: go to BIAS for c+1, or to IDLE when c=N_CLASS-1.
- Pipeline: RAM read registered (1 cycle) → product `$signed(w)·$signed({1'b0,x})` registered → accumulate.
  - Accumulator loads `sext(bias)` at the end of MAC cycle 0.
  - The first product is added at the end of MAC cycle 2.
- Accumulation saturates to the signed `ACC_W` range (clamp; never wraps).
- STORE writes the accumulator into RESULT_c and updates argmax.
  - Argmax uses strictly-greater comparison, so a tie keeps the lower index.
  - c=0 initialises the argmax unconditionally.
- Run end: `busy` clears, `done` sets (sticky), `DONE_IRQ` pulses.
- A start while `busy` is ignored. A start while idle clears `done` and begins at c=0.
- CPU memory writes while `busy` are dropped and set `err` (sticky).
- CTRL writes while `busy`:
  - A clear request clears `err` and leaves `done` unaffected.
  - A start request is ignored.
- Reads while `busy` are legal. Result registers not yet rewritten in the current run hold their previous values.
- Reset values:
  - `RDATA`=0, `DONE_IRQ`=0.
  - busy/done/err=0, all RESULT=0, ARGMAX=0, FSM=IDLE.
  - RAM contents are not reset.
- Reset mid-run aborts the run immediately; no IRQ is produced.

## Timing
- `RDATA` is valid the cycle after `RD` and holds until the next `RD`.
- Start write at cycle T:
  - `busy`=1 from T+1.
  - RESULT_c written at the end of cycle T+(c+1)(N_PIX+4).
  - `done`/`DONE_IRQ` at T+1+N_CLASS(N_PIX+4); `busy`=0 in the same cycle.
- A STATUS read in the cycle `done` sets returns the pre-update value.
- Simultaneous `WR` and `RD`: the write is applied; the read returns the state before that write.

## Structure
- Shared package holds: address-region constants, control register offsets, STATUS bit positions, the FSM state enum, and the `sat_add` width rule.
- One sub-module, `sp_ram_sync`: parametrised depth/width single-port RAM with 1-cycle registered read.
  - Instantiated three times: weight `N_CLASS·N_PIX`, image `N_PIX`, bias `N_CLASS`.
- Each RAM port is muxed between the CPU (idle) and the FSM (busy).

## Test plan
- N_PIX=4, N_CLASS=3:
  - Stimulus: image {1,2,3,4}, weights class0 {1,1,1,1}, class1 {-1,0,0,0}, class2 {2,2,2,2}, bias {5,0,-3}.
  - Required: RESULT = {15,-1,17}, ARGMAX=2, `DONE_IRQ` exactly at T+1+3·8=T+25.
- Tie: class0 and class2 both evaluate to 10, class1 to 3 → ARGMAX=0.
- Saturation with ACC_W=18, all pixels 255, weights 127, N_PIX=784 → RESULT=131071. With weights -128 → RESULT=-131072.
- Second start and image write while busy:
  - The start is ignored. The write is dropped: the image RAM location still reads its old value after the run.
  - STATUS reads 0b101 while busy and 0b110 after completion.
  - A CTRL bit1 write then gives STATUS=0.
- RESET_X low for 1 cycle mid-MAC of class1:
  - Immediately: RDATA=0, STATUS=0, RESULTs=0, no IRQ.
  - A following start reproduces the golden values of the first scenario.
- Read of ADR 0x30100+N_CLASS returns 0. RDATA holds its value when RD=0.
